// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one unified Read/Write/busywait memory between the MEM-stage data
// port and the instruction-fetch port, with data priority, a fetch starvation guard and a timeout.
module dmem_arbiter #(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        D_Read,
    input  logic        D_Write,
    input  logic [31:0] D_Address,
    input  logic [31:0] D_Write_data,
    input  logic [2:0]  D_Func3,
    output logic [31:0] D_Read_data,
    output logic        D_busywait,
    input  logic        I_Read,
    input  logic [31:0] I_Address,
    output logic [31:0] I_Read_data,
    output logic        I_busywait,
    output logic        mem_Read,
    output logic        mem_Write,
    output logic [31:0] mem_Address,
    output logic [31:0] mem_Write_data,
    output logic [2:0]  mem_Func3,
    input  logic [31:0] mem_Read_data,
    input  logic        mem_busywait,
    output logic        error
);
    localparam int          SC_W         = $clog2(STARVE_LIMIT + 1);
    localparam int          TC_W         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
    localparam logic [2:0]  FETCH_FUNC3  = 3'b010;

    typedef enum logic [1:0] { IDLE, MEM, RESP } state_t;
    typedef enum logic       { SEL_D, SEL_I }    sel_t;

    state_t          state, state_next;
    sel_t            sel;
    logic [SC_W-1:0] starve_cnt;
    logic [TC_W-1:0] tmo_cnt;
    logic [31:0]     rdata;
    logic [31:0]     d_rdata_hold, i_rdata_hold;

    logic d_req, i_req, starved;
    logic grant, grant_i;
    logic mem_done, mem_tmo;
    logic resp_d, resp_i;

    assign d_req   = D_Read | D_Write;
    assign i_req   = I_Read;
    assign starved = i_req && (starve_cnt == SC_W'(STARVE_LIMIT));
    assign resp_d  = (state == RESP) && (sel == SEL_D);
    assign resp_i  = (state == RESP) && (sel == SEL_I);

    // The first MEM cycle (tmo_cnt == 0) is skipped: the memory raises busywait only then.
    assign mem_done = (state == MEM) && (tmo_cnt != '0) && !mem_busywait;
    assign mem_tmo  = (state == MEM) && !mem_done && (tmo_cnt == TC_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        grant   = 1'b0;
        grant_i = 1'b0;
        case (state)
            IDLE: begin
                if (starved) begin
                    grant   = 1'b1;
                    grant_i = 1'b1;
                end else if (d_req) begin
                    grant   = 1'b1;
                end else if (i_req) begin
                    grant   = 1'b1;
                    grant_i = 1'b1;
                end
            end
            RESP: begin
                // Only the port not being acknowledged may follow back-to-back.
                if (resp_d && i_req) begin
                    grant   = 1'b1;
                    grant_i = 1'b1;
                end else if (resp_i && d_req) begin
                    grant   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = MEM;
            MEM:     if (mem_done || mem_tmo) state_next = RESP;
            RESP:    state_next = grant ? MEM : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        D_busywait  = d_req & ~resp_d;
        I_busywait  = i_req & ~resp_i;
        D_Read_data = resp_d ? rdata : d_rdata_hold;
        I_Read_data = resp_i ? rdata : i_rdata_hold;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sel            <= SEL_D;
            starve_cnt     <= '0;
            tmo_cnt        <= '0;
            rdata          <= '0;
            d_rdata_hold   <= '0;
            i_rdata_hold   <= '0;
            mem_Read       <= 1'b0;
            mem_Write      <= 1'b0;
            mem_Address    <= '0;
            mem_Write_data <= '0;
            mem_Func3      <= '0;
            error          <= 1'b0;
        end else begin
            if (grant) begin
                tmo_cnt <= '0;
                if (grant_i) begin
                    sel         <= SEL_I;
                    starve_cnt  <= '0;
                    mem_Read    <= 1'b1;
                    mem_Write   <= 1'b0;
                    mem_Address <= I_Address;
                    mem_Func3   <= FETCH_FUNC3;
                end else begin
                    sel            <= SEL_D;
                    mem_Read       <= D_Read;
                    mem_Write      <= D_Write & ~D_Read;
                    mem_Address    <= D_Address;
                    mem_Write_data <= D_Write_data;
                    mem_Func3      <= D_Func3;
                    if (I_Read && (starve_cnt != SC_W'(STARVE_LIMIT)))
                        starve_cnt <= starve_cnt + SC_W'(1);
                end
            end else if (state == MEM) begin
                if (mem_done || mem_tmo) begin
                    mem_Read  <= 1'b0;
                    mem_Write <= 1'b0;
                    rdata     <= mem_done ? mem_Read_data : TIMEOUT_DATA;
                    if (mem_tmo) error <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TC_W'(1);
                end
            end

            if (resp_d) d_rdata_hold <= rdata;
            if (resp_i) i_rdata_hold <= rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized concurrent
// D/I traffic scored against a transaction-level memory model.
module tb_dmem_arbiter;
    localparam int STARVE_LIMIT   = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        D_Read, D_Write;
    logic [31:0] D_Address, D_Write_data;
    logic [2:0]  D_Func3;
    logic [31:0] D_Read_data;
    logic        D_busywait;
    logic        I_Read;
    logic [31:0] I_Address;
    logic [31:0] I_Read_data;
    logic        I_busywait;
    logic        mem_Read, mem_Write;
    logic [31:0] mem_Address, mem_Write_data;
    logic [2:0]  mem_Func3;
    logic [31:0] mem_Read_data;
    logic        mem_busywait;
    logic        error;

    int passed = 0;
    int total  = 0;

    logic        i_read_drv;
    bit          starve_mode = 1'b0;
    bit          mem_stuck   = 1'b0;
    bit          rand_lat    = 1'b0;
    bit          load_mem    = 1'b0;
    logic [31:0] mem      [128];
    logic [31:0] init_mem [128];
    logic [31:0] ref_mem  [128];
    int          mem_cnt = 0;
    int          cur_lat = 1;

    dmem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .Clock(Clock), .Reset(Reset),
        .D_Read(D_Read), .D_Write(D_Write), .D_Address(D_Address),
        .D_Write_data(D_Write_data), .D_Func3(D_Func3),
        .D_Read_data(D_Read_data), .D_busywait(D_busywait),
        .I_Read(I_Read), .I_Address(I_Address),
        .I_Read_data(I_Read_data), .I_busywait(I_busywait),
        .mem_Read(mem_Read), .mem_Write(mem_Write), .mem_Address(mem_Address),
        .mem_Write_data(mem_Write_data), .mem_Func3(mem_Func3),
        .mem_Read_data(mem_Read_data), .mem_busywait(mem_busywait),
        .error(error)
    );

    always #5 Clock = ~Clock;

    // In starvation mode the fetch requester backs off only while D is being acknowledged.
    assign I_Read = starve_mode ? D_busywait : i_read_drv;

    // Memory with k-cycle latency: busywait rises with the request and falls after k cycles.
    assign mem_Read_data = mem[mem_Address[8:2]];
    assign mem_busywait  = mem_stuck | ((mem_Read | mem_Write) && (mem_cnt < cur_lat));

    always @(posedge Clock) begin
        if (load_mem) mem <= init_mem;
        else if (mem_Write && !mem_busywait) mem[mem_Address[8:2]] <= mem_Write_data;
        if (mem_Read | mem_Write) begin
            mem_cnt <= mem_cnt + 1;
        end else begin
            mem_cnt <= 0;
            cur_lat <= rand_lat ? int'($urandom_range(4, 1)) : 1;
        end
    end

    task automatic do_reset();
        Reset = 1'b1; D_Read = 1'b0; D_Write = 1'b0; D_Address = '0; D_Write_data = '0;
        D_Func3 = '0; i_read_drv = 1'b0; I_Address = '0; starve_mode = 1'b0; mem_stuck = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic load_memory();
        load_mem = 1'b1;
        @(negedge Clock);
        load_mem = 1'b0;
        for (int w = 0; w < 128; w++) ref_mem[w] = init_mem[w];
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (mem_Read !== 1'b0) $display("FAIL reset_mem_Read: got %b want 0", mem_Read); else passed++;
        total++; if (mem_Write !== 1'b0) $display("FAIL reset_mem_Write: got %b want 0", mem_Write); else passed++;
        total++; if (mem_Address !== 32'h0) $display("FAIL reset_mem_Address: got %h want 0", mem_Address); else passed++;
        total++; if (mem_Write_data !== 32'h0) $display("FAIL reset_mem_Write_data: got %h want 0", mem_Write_data); else passed++;
        total++; if (mem_Func3 !== 3'b0) $display("FAIL reset_mem_Func3: got %b want 0", mem_Func3); else passed++;
        total++; if (D_Read_data !== 32'h0) $display("FAIL reset_D_Read_data: got %h want 0", D_Read_data); else passed++;
        total++; if (I_Read_data !== 32'h0) $display("FAIL reset_I_Read_data: got %h want 0", I_Read_data); else passed++;
        total++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else passed++;
        total++; if (D_busywait !== 1'b0) $display("FAIL reset_D_busywait: got %b want 0", D_busywait); else passed++;
        total++; if (I_busywait !== 1'b0) $display("FAIL reset_I_busywait: got %b want 0", I_busywait); else passed++;
    endtask

    task automatic test_single_load();
        do_reset();
        D_Read = 1'b1; D_Address = 32'h10; D_Func3 = 3'b010;
        #1;
        total++; if (D_busywait !== 1'b1) $display("FAIL load_c0_busy: got %b want 1", D_busywait); else passed++;
        for (int c = 1; c <= 3; c++) begin
            @(negedge Clock);
            total++;
            if (mem_Read !== (c <= 2)) $display("FAIL load_c%0d_mem_Read: got %b want %b", c, mem_Read, c <= 2);
            else passed++;
            total++;
            if (D_busywait !== (c != 3)) $display("FAIL load_c%0d_busy: got %b want %b", c, D_busywait, c != 3);
            else passed++;
            if (c == 1) begin
                total++;
                if (mem_Address !== 32'h10) $display("FAIL load_addr: got %h want 00000010", mem_Address);
                else passed++;
            end
        end
        total++; if (D_Read_data !== 32'hCAFEBABE) $display("FAIL load_data: got %h want cafebabe", D_Read_data); else passed++;
        D_Read = 1'b0;
        @(negedge Clock);
    endtask

    task automatic test_store_then_fetch();
        do_reset();
        D_Write = 1'b1; D_Address = 32'h20; D_Write_data = 32'h11223344; D_Func3 = 3'b010;
        i_read_drv = 1'b1; I_Address = 32'h20;
        @(negedge Clock);
        total++; if (mem_Write !== 1'b1 || mem_Read !== 1'b0) $display("FAIL sf_d_first: got R%b W%b want R0 W1", mem_Read, mem_Write); else passed++;
        total++; if (mem_Write_data !== 32'h11223344) $display("FAIL sf_wdata: got %h want 11223344", mem_Write_data); else passed++;
        repeat (2) @(negedge Clock);
        total++; if (D_busywait !== 1'b0 || I_busywait !== 1'b1) $display("FAIL sf_d_resp: got D%b I%b want D0 I1", D_busywait, I_busywait); else passed++;
        D_Write = 1'b0; D_Func3 = 3'b100;
        @(negedge Clock);
        total++; if (mem_Read !== 1'b1 || mem_Address !== 32'h20) $display("FAIL sf_i_grant: got R%b addr %h want R1 addr 00000020", mem_Read, mem_Address); else passed++;
        total++; if (mem_Func3 !== 3'b010) $display("FAIL sf_i_func3: got %b want 010", mem_Func3); else passed++;
        repeat (2) @(negedge Clock);
        total++; if (I_busywait !== 1'b0) $display("FAIL sf_i_resp: got %b want 0", I_busywait); else passed++;
        total++; if (I_Read_data !== 32'h11223344) $display("FAIL sf_i_data: got %h want 11223344", I_Read_data); else passed++;
        i_read_drv = 1'b0;
        @(negedge Clock);
    endtask

    task automatic test_starvation();
        bit is_i [10];
        int n    = 0;
        bit prev = 1'b0;
        do_reset();
        D_Read = 1'b1; D_Address = 32'h100; D_Func3 = 3'b010; I_Address = 32'h8; starve_mode = 1'b1;
        for (int c = 0; c < 300 && n < 10; c++) begin
            @(negedge Clock);
            if (mem_Read && !prev) begin
                is_i[n] = (mem_Address == 32'h8);
                n++;
            end
            prev = mem_Read;
        end
        D_Read = 1'b0; starve_mode = 1'b0;
        total++; if (n != 10) $display("FAIL starve_grants: got %0d grants want 10", n); else passed++;
        for (int k = 0; k < n; k++) begin
            total++;
            if (is_i[k] !== (k == STARVE_LIMIT || k == 2 * STARVE_LIMIT + 1))
                $display("FAIL starve_grant%0d: got is_i=%b want %b", k, is_i[k], (k == STARVE_LIMIT || k == 2 * STARVE_LIMIT + 1));
            else passed++;
        end
    endtask

    task automatic test_timeout();
        int resp_c   = -1;
        int rd_cycles = 0;
        bit got      = 1'b0;
        do_reset();
        mem_stuck = 1'b1;
        D_Read = 1'b1; D_Address = 32'h40; D_Func3 = 3'b010;
        for (int c = 1; c <= 40 && resp_c < 0; c++) begin
            @(negedge Clock);
            if (mem_Read) rd_cycles++;
            if (c == 1) begin
                total++; if (error !== 1'b0) $display("FAIL tmo_error_early: got %b want 0", error); else passed++;
            end
            if (D_busywait === 1'b0) resp_c = c;
        end
        total++; if (resp_c != TIMEOUT_CYCLES + 1) $display("FAIL tmo_resp_cycle: got %0d want %0d", resp_c, TIMEOUT_CYCLES + 1); else passed++;
        total++; if (rd_cycles != TIMEOUT_CYCLES) $display("FAIL tmo_mem_cycles: got %0d want %0d", rd_cycles, TIMEOUT_CYCLES); else passed++;
        total++; if (D_Read_data !== 32'hDEADBEEF) $display("FAIL tmo_data: got %h want deadbeef", D_Read_data); else passed++;
        total++; if (error !== 1'b1) $display("FAIL tmo_error: got %b want 1", error); else passed++;
        D_Read = 1'b0; mem_stuck = 1'b0;
        @(negedge Clock);
        D_Read = 1'b1; D_Address = 32'h14;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge Clock);
            if (D_busywait === 1'b0) got = 1'b1;
        end
        total++; if (!got || D_Read_data !== init_mem[5]) $display("FAIL tmo_after_read: got %h (done=%b) want %h", D_Read_data, got, init_mem[5]); else passed++;
        total++; if (error !== 1'b1) $display("FAIL tmo_error_sticky: got %b want 1", error); else passed++;
        D_Read = 1'b0;
        do_reset();
        total++; if (error !== 1'b0) $display("FAIL tmo_error_cleared: got %b want 0", error); else passed++;
    endtask

    task automatic test_reset_in_mem();
        do_reset();
        D_Read = 1'b1; D_Address = 32'h10; D_Func3 = 3'b010;
        @(negedge Clock);
        total++; if (mem_Read !== 1'b1) $display("FAIL rim_c1_mem_Read: got %b want 1", mem_Read); else passed++;
        Reset = 1'b1;
        for (int c = 2; c <= 3; c++) begin
            @(negedge Clock);
            total++; if (mem_Read !== 1'b0) $display("FAIL rim_c%0d_mem_Read: got %b want 0", c, mem_Read); else passed++;
            total++; if (D_busywait !== 1'b1) $display("FAIL rim_c%0d_busy: got %b want 1", c, D_busywait); else passed++;
        end
        Reset = 1'b0;
        for (int c = 4; c <= 5; c++) begin
            @(negedge Clock);
            total++; if (mem_Read !== 1'b1 || D_busywait !== 1'b1) $display("FAIL rim_c%0d_reissue: got R%b busy%b want R1 busy1", c, mem_Read, D_busywait); else passed++;
        end
        @(negedge Clock);
        total++; if (D_busywait !== 1'b0) $display("FAIL rim_resp: got %b want 0", D_busywait); else passed++;
        total++; if (D_Read_data !== 32'hCAFEBABE) $display("FAIL rim_data: got %h want cafebabe", D_Read_data); else passed++;
        D_Read = 1'b0;
        @(negedge Clock);
    endtask

    task automatic test_illegal_rw();
        do_reset();
        D_Read = 1'b1; D_Write = 1'b1; D_Address = 32'h30; D_Write_data = 32'h55555555; D_Func3 = 3'b010;
        @(negedge Clock);
        total++; if (mem_Read !== 1'b1 || mem_Write !== 1'b0) $display("FAIL rw_mask: got R%b W%b want R1 W0", mem_Read, mem_Write); else passed++;
        repeat (2) @(negedge Clock);
        total++; if (D_busywait !== 1'b0 || D_Read_data !== 32'h0BADF00D) $display("FAIL rw_read: got busy%b %h want busy0 0badf00d", D_busywait, D_Read_data); else passed++;
        D_Read = 1'b0; D_Write = 1'b0;
        @(negedge Clock);
        total++; if (mem[12] !== 32'h0BADF00D) $display("FAIL rw_mem_unchanged: got %h want 0badf00d", mem[12]); else passed++;
    endtask

    // Data agent: reads anywhere, writes only the upper half; the model memory is updated on ack.
    task automatic d_agent(input int n);
        int          op, w, waited;
        logic [31:0] wd;
        bit          got;
        for (int t = 0; t < n; t++) begin
            op = int'($urandom_range(2, 0));
            w  = (op == 1) ? int'($urandom_range(127, 64)) : int'($urandom_range(127, 0));
            wd = $urandom;
            repeat ($urandom_range(3, 0)) @(negedge Clock);
            D_Read = (op != 1); D_Write = (op != 0); D_Address = 32'(w) << 2;
            D_Write_data = wd; D_Func3 = 3'b010;
            got = 1'b0;
            for (waited = 0; waited < 100 && !got; waited++) begin
                @(negedge Clock);
                if (D_busywait === 1'b0) got = 1'b1;
            end
            total++;
            if (!got) $display("FAIL rnd_d_ack%0d: no ack within 100 cycles, want ack", t);
            else if (op == 1) begin
                ref_mem[w] = wd;
                passed++;
            end else if (D_Read_data !== ref_mem[w])
                $display("FAIL rnd_d_read%0d: got %h want %h (word %0d)", t, D_Read_data, ref_mem[w], w);
            else passed++;
            D_Read = 1'b0; D_Write = 1'b0;
        end
    endtask

    // Fetch agent: reads only the lower half, which the data agent never writes.
    task automatic i_agent(input int n);
        int  w, waited;
        bit  got;
        for (int t = 0; t < n; t++) begin
            w = int'($urandom_range(63, 0));
            repeat ($urandom_range(3, 0)) @(negedge Clock);
            i_read_drv = 1'b1; I_Address = 32'(w) << 2;
            got = 1'b0;
            for (waited = 0; waited < 100 && !got; waited++) begin
                @(negedge Clock);
                if (I_busywait === 1'b0) got = 1'b1;
            end
            total++;
            if (!got) $display("FAIL rnd_i_ack%0d: no ack within 100 cycles, want ack", t);
            else if (I_Read_data !== ref_mem[w])
                $display("FAIL rnd_i_read%0d: got %h want %h (word %0d)", t, I_Read_data, ref_mem[w], w);
            else passed++;
            i_read_drv = 1'b0;
        end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int w = 0; w < 128; w++) init_mem[w] = $urandom;
        load_memory();
        rand_lat = 1'b1;
        fork
            d_agent(40);
            i_agent(40);
        join
        rand_lat = 1'b0;
        repeat (3) @(negedge Clock);
        for (int w = 0; w < 128; w++) if (mem[w] !== ref_mem[w]) bad++;
        total++; if (bad != 0) $display("FAIL rnd_mem_image: got %0d differing words want 0", bad); else passed++;
        total++; if (error !== 1'b0) $display("FAIL rnd_error: got %b want 0", error); else passed++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500us, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int w = 0; w < 128; w++) init_mem[w] = $urandom;
        init_mem[4]  = 32'hCAFEBABE;
        init_mem[12] = 32'h0BADF00D;
        load_mem = 1'b1;
        do_reset();
        load_mem = 1'b0;
        test_reset();
        test_single_load();
        test_store_then_fetch();
        test_starvation();
        test_timeout();
        test_reset_in_mem();
        test_illegal_rw();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer between the pipeline's data port (MEM stage load/store) and instruction-fetch port, sharing one Data_Memory-style unified memory with a Read/Write/busywait handshake. It grants one requester at a time and registers the granted request onto the memory port. It waits for the memory to complete, then returns read data and releases the requester's busywait. Data accesses have priority, and a starvation guard protects fetch.

## Interface
- STARVE_LIMIT, 4: consecutive D grants allowed while I is pending before I is forced.
- TIMEOUT_CYCLES, 16: maximum cycles in MEM before the access is aborted.
- Clock  input  1  system clock, all state on posedge.
- Reset  input  1  synchronous, active-high.
- D_Read, D_Write  input  1 each  data-port request.
- D_Address, D_Write_data  input  32 each  data-port address and store data.
- D_Func3  input  3  data-port access size/sign.
- D_Read_data  output  32  load result.
- D_busywait  output  1  data-port stall.
- I_Read  input  1  fetch request.
- I_Address  input  32  fetch address.
- I_Read_data  output  32  fetched word.
- I_busywait  output  1  fetch-port stall.
- mem_Read, mem_Write  output  1 each  memory-port request.
- mem_Address, mem_Write_data  output  32 each  memory-port address and store data.
- mem_Func3  output  3  memory-port access size/sign.
- mem_Read_data  input  32  memory read data.
- mem_busywait  input  1  memory stall.
- error  output  1  sticky timeout flag.

## Operation
- States: IDLE, MEM, RESP. Register sel (D/I), starve_cnt (saturating at STARVE_LIMIT), tmo_cnt, rdata.
- Requests:
  - D request = D_Read|D_Write.
  - D_Read&D_Write both high is treated as a read (D_Write masked).
  - I request = I_Read; fetch is always a read with Func3=3'b010.
- Arbitration:
  - In IDLE: if I pending and starve_cnt==STARVE_LIMIT, grant I.
  - Otherwise grant D if pending, else I if pending, else stay IDLE.
  - In RESP: only the port *not* being acknowledged may be granted, which gives a back-to-back RESP->MEM transition. Otherwise go to IDLE.
- Grant edge:
  - Latch the port's Read/Write/Address/Write_data/Func3 into the mem_* registers.
  - Clear tmo_cnt and go to MEM.
- starve_cnt:
  - Increments on a D grant while I_Read is high.
  - Clears on an I grant.
- MEM:
  - mem_* are held stable.
  - On each edge where tmo_cnt>=1 and mem_busywait==0: capture mem_Read_data into rdata, drop mem_Read/mem_Write, go to RESP.
  - The first MEM cycle ignores mem_busywait, because the memory raises it combinationally.
- Timeout: if tmo_cnt reaches TIMEOUT_CYCLES in MEM, drop the memory request, load rdata=32'hDEADBEEF, set error, go to RESP.
- RESP (one cycle):
  - The acked port's busywait is low.
  - The acked port's *_Read_data equals rdata.
- Busywait outputs (combinational):
  - D_busywait = D_req & ~(RESP & sel==D).
  - I_busywait = I_Read & ~(RESP & sel==I).
  - A port with no request always sees busywait 0.
- *_Read_data hold their last rdata outside RESP; only the value during RESP is defined.
- Requester drops its request mid-transaction: the memory operation still completes (stores are not cancelled), and the RESP cycle is consumed without effect.

## Timing
- Reset values (registered outputs):
  - State IDLE; mem_Read=mem_Write=0.
  - mem_Address, mem_Write_data, mem_Func3, rdata, D_Read_data, I_Read_data = 0.
  - starve_cnt=0, tmo_cnt=0, error=0.
- Reset mid-transaction:
  - Next edge forces IDLE and drops the memory request; the in-flight response is discarded.
  - Requesters keep busywait high while they hold their request.
- Single-access latency against a memory that completes in one cycle:
  - Cycle 0: request seen in IDLE.
  - Cycles 1-2: MEM.
  - Cycle 3: RESP; the requester samples busywait low and the data at the end of cycle 3.
  - A k-cycle memory adds k-1 cycles.
- Back-to-back alternating D/I: one access every 3 cycles (MEM, MEM, RESP).
- Simultaneous D and I requests in IDLE: D wins unless starve_cnt==STARVE_LIMIT.
- error clears only on Reset.

## Test plan
- Single load: D_Read=1, D_Address=0x10, D_Func3=010, memory preloaded with 0xCAFEBABE at word 4. Expect mem_Read high in cycles 1-2, D_busywait low only in cycle 3, D_Read_data=0xCAFEBABE.
- Store then fetch: D_Write with 0x11223344 to 0x20, I_Read at 0x20 pending at the same time. Expect D granted first, I granted in D's RESP cycle, I_Read_data=0x11223344, mem_Func3=010 during the fetch.
- Starvation: D requests held continuously with I_Read=1 and STARVE_LIMIT=4. Expect exactly 4 D grants, then an I grant, then starve_cnt=0.
- Timeout: mem_busywait tied to 1. Expect RESP after TIMEOUT_CYCLES, D_Read_data=0xDEADBEEF, error=1 sticky until Reset.
- Reset in MEM: assert Reset in cycle 1 of an access. Expect mem_Read=0 and IDLE next edge, no RESP, D_busywait stays 1 while D_Read is held, and the access re-issues after Reset falls.
- Illegal D_Read&D_Write: expect mem_Read=1 and mem_Write=0, with memory contents unchanged.
